kernel_pingpong_buffer: RTL and testbench

- Parametrised successor of the single 3x3 filter store.
- Holds two K×K kernels of DATA_W-bit weights in ping-pong banks.
- Producer side streams weights with a valid/ready handshake and auto-incrementing address. The convolution engine sees one complete kernel in parallel while the other bank loads, so filter switches cost no reload stall.
- Sits between the weight-fetch DMA and the 3x3/5x5 MAC array of the conv layer.

---
 rtl/kernel_pingpong_buffer.sv | 146 ++++++++++++++
 tb/tb_kernel_pingpong_buffer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_pingpong_buffer.sv
// Double-buffered K x K weight store between the weight-fetch DMA and the MAC array.
// One bank fills from a valid/ready word stream while the other is presented to the
// convolution engine as a complete parallel kernel, so filter switches need no reload.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous active-low reset
//   soft_clear    synchronous flush of both banks' state (active-high)
//   wr_valid      producer word valid
//   wr_ready      buffer can take a word this cycle (registers only)
//   wr_data       weight word, element 0 first
//   wr_count      elements already written into the current fill bank
//   kout_valid    kout_data holds a complete kernel
//   kout_data     kernel; element 0 at MSBs, element N-1 at LSBs
//   kout_bank     bank currently driving kout_data
//   kernel_done   consumer releases the presented kernel
//   err_underflow sticky: kernel_done seen with no kernel presented
module kernel_pingpong_buffer #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned K      = 3,
  parameter int unsigned ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     soft_clear,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [ADDR_W-1:0]        wr_count,
  output logic                     kout_valid,
  output logic [K*K*DATA_W-1:0]    kout_data,
  output logic                     kout_bank,
  input  logic                     kernel_done,
  output logic                     err_underflow
);

  localparam int unsigned N  = K * K;
  localparam int unsigned KW = N * DATA_W;

  // Each bank is kept already packed in output order.
  logic [KW-1:0]     bank_q [2];

  logic [1:0]        full_q, full_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [ADDR_W-1:0] wr_count_q, wr_count_d;
  logic              kout_valid_q, kout_valid_d;
  logic [KW-1:0]     kout_data_q, kout_data_d;
  logic              kout_bank_q, kout_bank_d;
  logic              err_q, err_d;

  logic              wr_fire, wr_last, rel_fire;

  always_comb begin
    wr_fire      = wr_valid && !full_q[wr_bank_q];
    wr_last      = (wr_count_q == ADDR_W'(N - 1));
    rel_fire     = kernel_done && kout_valid_q;

    full_d       = full_q;
    wr_bank_d    = wr_bank_q;
    rd_bank_d    = rd_bank_q;
    wr_count_d   = wr_count_q;
    kout_valid_d = kout_valid_q;
    kout_data_d  = kout_data_q;
    kout_bank_d  = kout_bank_q;
    err_d        = err_q;

    if (soft_clear) begin
      full_d       = '0;
      wr_bank_d    = 1'b0;
      rd_bank_d    = 1'b0;
      wr_count_d   = '0;
      kout_valid_d = 1'b0;
      kout_data_d  = '0;
      kout_bank_d  = 1'b0;
      err_d        = 1'b0;
    end else begin
      if (wr_fire) begin
        if (wr_last) begin
          wr_count_d          = '0;
          full_d[wr_bank_q]   = 1'b1;
          wr_bank_d           = ~wr_bank_q;
        end else begin
          wr_count_d = wr_count_q + ADDR_W'(1);
        end
      end

      // Release and a last write never target the same bank: that bank would be full.
      if (rel_fire) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else if (kernel_done) begin
        err_d = 1'b1;
      end

      // Presentation follows the pre-edge full flags, so a freshly filled bank appears one
      // cycle after its last write while an already-full bank appears right at a release.
      kout_valid_d = full_q[rd_bank_d];
      kout_bank_d  = rd_bank_d;
      if (kout_valid_d || rel_fire) begin
        kout_data_d = bank_q[rd_bank_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      full_q       <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      wr_count_q   <= '0;
      kout_valid_q <= 1'b0;
      kout_data_q  <= '0;
      kout_bank_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      full_q       <= full_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_count_q   <= wr_count_d;
      kout_valid_q <= kout_valid_d;
      kout_data_q  <= kout_data_d;
      kout_bank_q  <= kout_bank_d;
      err_q        <= err_d;
    end
  end

  // Bank storage is never cleared; a refill overwrites every element.
  always_ff @(posedge clk) begin
    if (reset && !soft_clear && wr_fire) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (wr_count_q == ADDR_W'(i)) begin
          bank_q[wr_bank_q][(N - 1 - i) * DATA_W +: DATA_W] <= wr_data;
        end
      end
    end
  end

  assign wr_ready      = !full_q[wr_bank_q];
  assign wr_count      = wr_count_q;
  assign kout_valid    = kout_valid_q;
  assign kout_data     = kout_data_q;
  assign kout_bank     = kout_bank_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_kernel_pingpong_buffer.sv
// Bench for kernel_pingpong_buffer: a K=3/8-bit instance for directed cases and a
// K=5/16-bit instance for randomised producer/consumer traffic with an in-order scoreboard.
// A kernel-queue model (completed kernels in order, each tagged with its completion edge)
// is compared against both instances every cycle.
module tb_kernel_pingpong_buffer;

  logic        clk;
  logic        rst  [2];
  logic        clr  [2];
  logic        wv   [2];
  logic        kd   [2];
  logic [15:0] wd   [2];
  logic        wrdy [2];
  logic        kv   [2];
  logic        kb   [2];
  logic        er   [2];
  logic [5:0]  wcnt [2];
  logic [71:0]  kdata_a;
  logic [399:0] kdata_b;
  logic [399:0] kdat [2];

  assign kdat[0] = {328'd0, kdata_a};
  assign kdat[1] = kdata_b;

  int checks = 0;
  int errors = 0;

  kernel_pingpong_buffer #(.DATA_W(8), .K(3), .ADDR_W(6)) u_dut_a (
    .clk          (clk),
    .reset        (rst[0]),
    .soft_clear   (clr[0]),
    .wr_valid     (wv[0]),
    .wr_ready     (wrdy[0]),
    .wr_data      (wd[0][7:0]),
    .wr_count     (wcnt[0]),
    .kout_valid   (kv[0]),
    .kout_data    (kdata_a),
    .kout_bank    (kb[0]),
    .kernel_done  (kd[0]),
    .err_underflow(er[0])
  );

  kernel_pingpong_buffer #(.DATA_W(16), .K(5), .ADDR_W(6)) u_dut_b (
    .clk          (clk),
    .reset        (rst[1]),
    .soft_clear   (clr[1]),
    .wr_valid     (wv[1]),
    .wr_ready     (wrdy[1]),
    .wr_data      (wd[1]),
    .wr_count     (wcnt[1]),
    .kout_valid   (kv[1]),
    .kout_data    (kdata_b),
    .kout_bank    (kb[1]),
    .kernel_done  (kd[1]),
    .err_underflow(er[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [399:0] act, input logic [399:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           ecnt = 0;
  int           mfill [2];
  logic [399:0] macc  [2];
  int           mq_n  [2];
  logic [399:0] mq_d  [2][2];
  int           mq_e  [2][2];
  int           mrel  [2];
  bit           merr  [2];

  // A completed kernel is shown from the edge after the one that completed it.
  function automatic bit mvalid(input int i);
    return (mq_n[i] > 0) && (mq_e[i][0] < ecnt);
  endfunction

  // Inputs change just after posedge, so at negedge they are what the next posedge samples.
  always @(negedge clk) begin
    bit           v, rdy;
    int           dw, n;
    logic [399:0] mask;
    string        nm;
    for (int i = 0; i < 2; i++) begin
      nm = (i == 0) ? "a" : "b";
      if (ecnt > 0) begin
        chk({nm, "_wr_ready"}, 400'(wrdy[i]), (mq_n[i] < 2) ? 400'd1 : 400'd0);
        chk({nm, "_wr_count"}, 400'(wcnt[i]), 400'(mfill[i]));
        chk({nm, "_kout_valid"}, 400'(kv[i]), 400'(mvalid(i)));
        chk({nm, "_kout_bank"}, 400'(kb[i]), 400'(mrel[i] % 2));
        chk({nm, "_err"}, 400'(er[i]), 400'(merr[i]));
        if (mvalid(i)) chk({nm, "_kout_data"}, kdat[i], mq_d[i][0]);
      end
      dw  = (i == 0) ? 8 : 16;
      n   = (i == 0) ? 9 : 25;
      v   = mvalid(i);
      rdy = (mq_n[i] < 2);
      if (!rst[i] || clr[i]) begin
        mfill[i] = 0;
        macc[i]  = '0;
        mq_n[i]  = 0;
        mrel[i]  = 0;
        merr[i]  = 1'b0;
      end else begin
        if (kd[i] && v) begin
          mq_d[i][0] = mq_d[i][1];
          mq_e[i][0] = mq_e[i][1];
          mq_n[i]--;
          mrel[i]++;
        end else if (kd[i]) begin
          merr[i] = 1'b1;
        end
        if (wv[i] && rdy) begin
          mask    = (400'd1 << dw) - 400'd1;
          macc[i] = (macc[i] << dw) | ({384'd0, wd[i]} & mask);
          mfill[i]++;
          if (mfill[i] == n) begin
            mq_d[i][mq_n[i]] = macc[i];
            mq_e[i][mq_n[i]] = ecnt + 1;
            mq_n[i]++;
            mfill[i] = 0;
            macc[i]  = '0;
          end
        end
      end
    end
    ecnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [7:0] first, input int cnt);
    for (int j = 0; j < cnt; j++) begin
      wv[0] = 1'b1;
      wd[0] = 16'(first + 8'(j));
      tick();
    end
    wv[0] = 1'b0;
  endtask

  initial begin
    int           sent, got;
    logic [399:0] expk;
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; clr[i] = 1'b0; wv[i] = 1'b0; kd[i] = 1'b0; wd[i] = '0;
    end
    tick();
    tick();
    // Reset state.
    chk("rst_wr_ready", 400'(wrdy[0]), 400'd1);
    chk("rst_kout_valid", 400'(kv[0]), 400'd0);
    chk("rst_wr_count", 400'(wcnt[0]), 400'd0);
    chk("rst_kout_data", kdat[0], 400'd0);
    chk("rst_kout_bank", 400'(kb[0]), 400'd0);
    chk("rst_err", 400'(er[0]), 400'd0);
    rst[0] = 1'b1;
    rst[1] = 1'b1;

    // Fill bank 0: valid lands one cycle after the last accept.
    for (int j = 0; j < 9; j++) begin
      wv[0] = 1'b1;
      wd[0] = 16'(j + 1);
      tick();
      chk("fill0_ready", 400'(wrdy[0]), 400'd1);
    end
    wv[0] = 1'b0;
    chk("fill0_not_yet", 400'(kv[0]), 400'd0);
    tick();
    chk("fill0_valid", 400'(kv[0]), 400'd1);
    chk("fill0_data", kdat[0], 400'h010203040506070809);
    chk("fill0_bank", 400'(kb[0]), 400'd0);

    // Fill bank 1 while bank 0 is held, then a 10th word must be refused.
    write_a(8'h11, 9);
    chk("both_full_ready", 400'(wrdy[0]), 400'd0);
    wv[0] = 1'b1;
    wd[0] = 16'h1A;
    tick();
    tick();
    wv[0] = 1'b0;
    chk("refused_count", 400'(wcnt[0]), 400'd0);
    chk("refused_ready", 400'(wrdy[0]), 400'd0);
    chk("held_data", kdat[0], 400'h010203040506070809);

    // Release bank 0: bank 1 shows immediately, producer unblocked.
    kd[0] = 1'b1;
    tick();
    kd[0] = 1'b0;
    chk("swap_valid", 400'(kv[0]), 400'd1);
    chk("swap_bank", 400'(kb[0]), 400'd1);
    chk("swap_data", kdat[0], 400'h111213141516171819);
    chk("swap_ready", 400'(wrdy[0]), 400'd1);

    // Release bank 1 with bank 0 empty, then underflow.
    kd[0] = 1'b1;
    tick();
    chk("empty_valid", 400'(kv[0]), 400'd0);
    chk("empty_bank", 400'(kb[0]), 400'd0);
    tick();
    kd[0] = 1'b0;
    chk("uflow_err", 400'(er[0]), 400'd1);
    chk("uflow_valid", 400'(kv[0]), 400'd0);
    tick();
    tick();
    chk("uflow_sticky", 400'(er[0]), 400'd1);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("clear_err", 400'(er[0]), 400'd0);

    // Partial fill discarded by soft_clear, then by reset.
    write_a(8'h33, 3);
    chk("part_count3", 400'(wcnt[0]), 400'd3);
    clr[0] = 1'b1;
    tick();
    clr[0] = 1'b0;
    chk("clr_count", 400'(wcnt[0]), 400'd0);
    write_a(8'h55, 4);
    chk("part_count4", 400'(wcnt[0]), 400'd4);
    rst[0] = 1'b0;
    tick();
    rst[0] = 1'b1;
    chk("rst_count", 400'(wcnt[0]), 400'd0);
    write_a(8'hA0, 9);
    tick();
    chk("refill_valid", 400'(kv[0]), 400'd1);
    chk("refill_bank", 400'(kb[0]), 400'd0);
    chk("refill_data", kdat[0], 400'hA0A1A2A3A4A5A6A7A8);

    // Back-to-back: bank 1 already full at release, no idle cycle.
    write_a(8'hB0, 9);
    tick();
    kd[0] = 1'b1;
    tick();
    kd[0] = 1'b0;
    chk("b2b_valid", 400'(kv[0]), 400'd1);
    chk("b2b_bank", 400'(kb[0]), 400'd1);
    chk("b2b_data", kdat[0], 400'hB0B1B2B3B4B5B6B7B8);

    // Random gaps on the K=5 instance; every kernel must arrive once, in order.
    sent = 0;
    got  = 0;
    for (int c = 0; c < 4000 && got < 6; c++) begin
      if (sent < 150) begin
        wv[1] = ($urandom_range(0, 9) < 7);
        wd[1] = {8'(sent / 25), 8'(sent % 25)};
      end else begin
        wv[1] = 1'b0;
      end
      kd[1] = kv[1] && ($urandom_range(0, 9) < 3);
      if (kd[1]) begin
        expk = '0;
        for (int e = 0; e < 25; e++) expk = (expk << 16) | {384'd0, 8'(got), 8'(e)};
        chk("sb_kernel", kdat[1], expk);
        got++;
      end
      if (wv[1] && wrdy[1]) sent++;
      tick();
    end
    wv[1] = 1'b0;
    kd[1] = 1'b0;
    tick();
    chk("sb_count", 400'(got), 400'd6);
    chk("sb_err", 400'(er[1]), 400'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
